// File: rtl/trap_redirect_ctrl_pkg.sv
// trap_redirect_ctrl_pkg: state and event-kind encodings shared by the trap redirect sequencer.
package trap_redirect_ctrl_pkg;
  typedef enum logic [1:0] {
    TRAP_ST_IDLE     = 2'd0,
    TRAP_ST_DRAIN    = 2'd1,
    TRAP_ST_REDIRECT = 2'd2
  } trap_st_e;
  typedef enum logic [1:0] {
    TRAP_KIND_ILLEGAL = 2'd0,
    TRAP_KIND_ECALL   = 2'd1,
    TRAP_KIND_MRET    = 2'd2
  } trap_kind_e;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/trap_redirect_ctrl_drain_timer.sv
// trap_redirect_ctrl_drain_timer: clear/enable cycle counter that expires at DRAIN_MAX-1.
module trap_redirect_ctrl_drain_timer #(
  parameter int unsigned DRAIN_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned W = $clog2(DRAIN_MAX) + 1;
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(DRAIN_MAX - 1);
  always_ff @(posedge clk)
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/trap_redirect_ctrl.sv
// trap_redirect_ctrl: sequences stall/drain/flush/redirect for traps and mret; TRAP_MISALIGN_CHECK_EN word-aligns mret targets and flags misalignment.
module trap_redirect_ctrl
  import trap_redirect_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             illegal_inst,
  input  logic             ecall,
  input  logic             mret,
  input  logic [31:0]      csr_rdata,
  input  logic             lsu_busy,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic             trap_taken,
  output logic             mret_taken,
  output logic             drain_timeout,
  output logic             misalign,
  output logic [CNT_W-1:0] trap_count
);
  trap_st_e   state_q;
  trap_kind_e kind_q, kind_d;
  logic [31:0] pc_q, target_d, mret_tgt;
  logic [CNT_W-1:0] count_q;
  logic flush_q, timeout_q, mis_q, mis_d, evt, hs, expired;
`ifdef TRAP_MISALIGN_CHECK_EN
  assign mret_tgt = word_align(csr_rdata);
  assign mis_d    = |csr_rdata[1:0];
`else
  assign mret_tgt = csr_rdata & 32'hFFFF_FFFE;
  assign mis_d    = 1'b0;
`endif
  assign evt      = illegal_inst | ecall | mret;
  assign kind_d   = illegal_inst ? TRAP_KIND_ILLEGAL : ecall ? TRAP_KIND_ECALL : TRAP_KIND_MRET;
  assign target_d = kind_d == TRAP_KIND_MRET ? mret_tgt : word_align(csr_rdata);
  assign hs       = state_q == TRAP_ST_REDIRECT && fetch_ready;
  assign redirect_valid = state_q == TRAP_ST_REDIRECT;
  assign redirect_pc    = pc_q;
  assign flush          = flush_q;
  assign stall          = state_q != TRAP_ST_IDLE || evt;
  assign trap_taken     = hs && kind_q != TRAP_KIND_MRET;
  assign mret_taken     = hs && kind_q == TRAP_KIND_MRET;
  assign misalign       = mret_taken && mis_q;
  assign drain_timeout  = timeout_q;
  assign trap_count     = count_q;
  trap_redirect_ctrl_drain_timer #(.DRAIN_MAX(DRAIN_MAX)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != TRAP_ST_DRAIN),
    .en_i      (state_q == TRAP_ST_DRAIN),
    .expired_o (expired)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= TRAP_ST_IDLE;
      kind_q    <= TRAP_KIND_ILLEGAL;
      pc_q      <= '0;
      mis_q     <= 1'b0;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      flush_q <= state_q == TRAP_ST_IDLE && evt;
      case (state_q)
        TRAP_ST_IDLE: if (evt) begin
          kind_q  <= kind_d;
          pc_q    <= target_d;
          mis_q   <= mis_d;
          state_q <= lsu_busy ? TRAP_ST_DRAIN : TRAP_ST_REDIRECT;
        end
        TRAP_ST_DRAIN: if (!lsu_busy || expired) begin
          state_q <= TRAP_ST_REDIRECT;
          if (lsu_busy) timeout_q <= 1'b1;
        end
        TRAP_ST_REDIRECT: if (fetch_ready) begin
          state_q <= TRAP_ST_IDLE;
          if (kind_q != TRAP_KIND_MRET && !(&count_q)) count_q <= count_q + 1'b1;
        end
        default: state_q <= TRAP_ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// tb_trap_redirect_ctrl: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_trap_redirect_ctrl;
  localparam int CNT_W = 8;
  localparam int DRAIN_MAX = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1, illegal_inst = 0, ecall = 0, mret = 0, lsu_busy = 0, fetch_ready = 0;
  logic [31:0] csr_rdata = 0;
  logic redirect_valid, flush, stall, trap_taken, mret_taken, drain_timeout, misalign;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] trap_count;
  always #5 clk = ~clk;
  trap_redirect_ctrl #(.CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst), .illegal_inst(illegal_inst), .ecall(ecall), .mret(mret),
    .csr_rdata(csr_rdata), .lsu_busy(lsu_busy), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .stall(stall),
    .trap_taken(trap_taken), .mret_taken(mret_taken), .drain_timeout(drain_timeout),
    .misalign(misalign), .trap_count(trap_count)
  );
  int checks = 0, errors = 0;
  bit m_act, m_drn, m_trap, m_mis, m_flush, m_to;
  int m_dcnt, m_cnt;
  logic [31:0] m_pc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_act = 0; m_drn = 0; m_trap = 0; m_mis = 0; m_flush = 0; m_to = 0; m_dcnt = 0; m_cnt = 0; m_pc = 0;
  endtask
  task automatic step(input bit r, ill, ec, mr, input logic [31:0] rd, input bit b, fr);
    bit ev, hs;
    @(negedge clk);
    rst = r; illegal_inst = ill; ecall = ec; mret = mr; csr_rdata = rd; lsu_busy = b; fetch_ready = fr;
    #1;
    ev = ill | ec | mr;
    hs = m_act && !m_drn && fr;
    chk("redirect_valid", 32'(redirect_valid), 32'(m_act && !m_drn));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("flush", 32'(flush), 32'(m_flush));
    chk("stall", 32'(stall), 32'(m_act || ev));
    chk("trap_taken", 32'(trap_taken), 32'(hs && m_trap));
    chk("mret_taken", 32'(mret_taken), 32'(hs && !m_trap));
`ifdef TRAP_MISALIGN_CHECK_EN
    chk("misalign", 32'(misalign), 32'(hs && !m_trap && m_mis));
`else
    chk("misalign", 32'(misalign), 0);
`endif
    chk("drain_timeout", 32'(drain_timeout), 32'(m_to));
    chk("trap_count", 32'(trap_count), m_cnt);
    if (r) model_reset();
    else begin
      m_flush = !m_act && ev;
      if (!m_act) begin
        if (ev) begin
          m_act = 1; m_drn = b; m_dcnt = 0; m_trap = ill | ec;
`ifdef TRAP_MISALIGN_CHECK_EN
          m_pc = m_trap ? rd & ~32'd3 : rd & ~32'd3;
          m_mis = (rd % 4) != 0;
`else
          m_pc = m_trap ? rd & ~32'd3 : rd & ~32'd1;
          m_mis = 0;
`endif
        end
      end else if (m_drn) begin
        if (!b) m_drn = 0;
        else if (m_dcnt == DRAIN_MAX - 1) begin m_drn = 0; m_to = 1; end
        else m_dcnt++;
      end else if (fr) begin
        m_act = 0;
        if (m_trap && m_cnt < CMAX) m_cnt++;
      end
    end
  endtask
  typedef struct {
    bit ill, ec, mr; logic [31:0] rd; bit b, fr;
    bit v; logic [31:0] pc; bit fl, st, tt, mt;
  } vec_t;
  vec_t tbl[6];
  initial begin
    tbl[0] = '{0, 1, 0, 32'h103, 0, 1, 0, 32'h000, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 32'h000, 0, 1, 1, 32'h100, 1, 1, 1, 0};
    tbl[2] = '{0, 0, 0, 32'h000, 0, 1, 0, 32'h100, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 32'h200, 0, 1, 0, 32'h100, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 32'h000, 0, 1, 1, 32'h200, 1, 1, 1, 0};
    tbl[5] = '{0, 0, 0, 32'h000, 0, 1, 0, 32'h200, 0, 0, 0, 0};
    model_reset();
    repeat (3) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", 32'(redirect_valid), 0);
    chk("reset_pc", redirect_pc, 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_count", 32'(trap_count), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, tbl[i].ill, tbl[i].ec, tbl[i].mr, tbl[i].rd, tbl[i].b, tbl[i].fr);
      chk($sformatf("vec%0d_valid", i), 32'(redirect_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_pc", i), redirect_pc, tbl[i].pc);
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].fl));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("vec%0d_trap", i), 32'(trap_taken), 32'(tbl[i].tt));
      chk($sformatf("vec%0d_mret", i), 32'(mret_taken), 32'(tbl[i].mt));
    end
    chk("table_count", 32'(trap_count), 2);
    // lsu busy for three cycles: DRAIN N+1..N+3, redirect visible at N+4
    step(0, 0, 1, 0, 32'h300, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain3_valid_n3", 32'(redirect_valid), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("drain3_valid_n4", 32'(redirect_valid), 1);
    chk("drain3_timeout", 32'(drain_timeout), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // lsu stuck busy: eight DRAIN cycles, then forced redirect and sticky timeout
    step(0, 0, 1, 0, 32'h500, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("to_valid_n8", 32'(redirect_valid), 0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("to_valid_n9", 32'(redirect_valid), 1);
    chk("to_flag", 32'(drain_timeout), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("to_sticky", 32'(drain_timeout), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("to_cleared", 32'(drain_timeout), 0);
    // mret with fetch stalled; new events meanwhile are ignored
    step(0, 0, 0, 1, 32'h406, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, i[0], 1, 1, 32'hDEAD_BEEF, 0, 0);
`ifdef TRAP_MISALIGN_CHECK_EN
      chk("mret_wait_pc", redirect_pc, 32'h404);
`else
      chk("mret_wait_pc", redirect_pc, 32'h406);
`endif
      chk("mret_wait_valid", 32'(redirect_valid), 1);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    chk("mret_hs_taken", 32'(mret_taken), 1);
    chk("mret_hs_trap", 32'(trap_taken), 0);
`ifdef TRAP_MISALIGN_CHECK_EN
    chk("mret_misalign", 32'(misalign), 1);
`else
    chk("mret_misalign", 32'(misalign), 0);
`endif
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mret_idle_valid", 32'(redirect_valid), 0);
    chk("mret_count", 32'(trap_count), 0);
    // reset while in REDIRECT
    step(0, 0, 1, 0, 32'h700, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_redir_valid", 32'(redirect_valid), 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_redir_stall", 32'(stall), 0);
    chk("rst_redir_flush", 32'(flush), 0);
    // counter saturation
    for (int i = 0; i < CMAX + 5; i++) begin
      step(0, 0, 1, 0, 32'h40, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
    end
    chk("count_saturated", 32'(trap_count), CMAX);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit ev;
      ev = $urandom_range(0, 3) == 0;
      step($urandom_range(0, 299) == 0, ev && $urandom_range(0, 1) == 1,
           ev && $urandom_range(0, 1) == 1, ev && $urandom_range(0, 2) != 0,
           $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
